// File: rtl/alu_op_issue.sv
// alu_op_issue: producer side of the EX-stage ALU interface.
// Decodes an RV32I instruction in ID into the 5-bit ALU control code, the
// immediate and the two ALU operands. The result is registered into a single
// ID/EX pipeline slot with a valid/ready handshake, stall and flush.
//
// Ports
//   i_clk, i_rst_n        clock (rising edge), asynchronous active-low reset
//   i_valid_ID/o_ready_ID ID-side handshake; transfer when both are high
//   i_instr_ID            raw 32-bit instruction
//   i_pc_ID               PC of the instruction
//   i_rs1/2_data_ID       forwarded register-file read data
//   i_flush_EX            kill slot contents; also drops the ID op on the same edge
//   i_ready_EX            EX consumes the slot this cycle
//   o_valid_EX            slot holds a valid op
//   o_alu_ctrl_EX         ALU control code
//   o_rd1_EX, o_rd2_EX    ALU operands A and B
//   o_imm_EX              decoded immediate (branch/store/jump offset)
//   o_branch_EX           op is a conditional branch
//   o_illegal_EX          opcode/funct not supported
module alu_op_issue #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid_ID,
    output logic             o_ready_ID,
    input  logic [31:0]      i_instr_ID,
    input  logic [WIDTH-1:0] i_pc_ID,
    input  logic [WIDTH-1:0] i_rs1_data_ID,
    input  logic [WIDTH-1:0] i_rs2_data_ID,
    input  logic             i_flush_EX,
    input  logic             i_ready_EX,
    output logic             o_valid_EX,
    output logic [4:0]       o_alu_ctrl_EX,
    output logic [WIDTH-1:0] o_rd1_EX,
    output logic [WIDTH-1:0] o_rd2_EX,
    output logic [WIDTH-1:0] o_imm_EX,
    output logic             o_branch_EX,
    output logic             o_illegal_EX
);

    localparam int unsigned CTRL_W = 5;

    localparam logic [CTRL_W-1:0] ALU_AND  = 5'd0;
    localparam logic [CTRL_W-1:0] ALU_OR   = 5'd1;
    localparam logic [CTRL_W-1:0] ALU_XOR  = 5'd2;
    localparam logic [CTRL_W-1:0] ALU_ADD  = 5'd3;
    localparam logic [CTRL_W-1:0] ALU_SUB  = 5'd4;
    localparam logic [CTRL_W-1:0] ALU_SLL  = 5'd5;
    localparam logic [CTRL_W-1:0] ALU_SRL  = 5'd6;
    localparam logic [CTRL_W-1:0] ALU_SLT  = 5'd7;
    localparam logic [CTRL_W-1:0] ALU_SLTU = 5'd8;
    localparam logic [CTRL_W-1:0] ALU_SRA  = 5'd9;
    localparam logic [CTRL_W-1:0] ALU_BEQ  = 5'd10;
    localparam logic [CTRL_W-1:0] ALU_BNE  = 5'd11;
    localparam logic [CTRL_W-1:0] ALU_BLT  = 5'd12;
    localparam logic [CTRL_W-1:0] ALU_BLTU = 5'd13;
    localparam logic [CTRL_W-1:0] ALU_BGE  = 5'd14;
    localparam logic [CTRL_W-1:0] ALU_BGEU = 5'd15;
    localparam logic [CTRL_W-1:0] ALU_LUI  = 5'd16;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // Instruction fields
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    assign opcode   = i_instr_ID[6:0];
    assign funct3   = i_instr_ID[14:12];
    assign funct7_5 = i_instr_ID[30];

    // Immediates, sign-extended from instr[31] to WIDTH
    logic [31:0]      imm_i32, imm_s32, imm_b32, imm_u32, imm_j32;
    logic [WIDTH-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt, four;
    assign imm_i32 = {{20{i_instr_ID[31]}}, i_instr_ID[31:20]};
    assign imm_s32 = {{20{i_instr_ID[31]}}, i_instr_ID[31:25], i_instr_ID[11:7]};
    assign imm_b32 = {{19{i_instr_ID[31]}}, i_instr_ID[31], i_instr_ID[7],
                      i_instr_ID[30:25], i_instr_ID[11:8], 1'b0};
    assign imm_u32 = {i_instr_ID[31:12], 12'b0};
    assign imm_j32 = {{11{i_instr_ID[31]}}, i_instr_ID[31], i_instr_ID[19:12],
                      i_instr_ID[20], i_instr_ID[30:21], 1'b0};
    assign imm_i   = WIDTH'($signed(imm_i32));
    assign imm_s   = WIDTH'($signed(imm_s32));
    assign imm_b   = WIDTH'($signed(imm_b32));
    assign imm_u   = WIDTH'($signed(imm_u32));
    assign imm_j   = WIDTH'($signed(imm_j32));
    assign shamt   = WIDTH'(i_instr_ID[24:20]);
    assign four    = WIDTH'(4);

    // Decoded payload for the instruction currently in ID
    logic [CTRL_W-1:0] dec_ctrl;
    logic [WIDTH-1:0]  dec_a, dec_b, dec_imm;
    logic              dec_branch, dec_illegal;

    // Combinational decode; unsupported encodings fall out as illegal with zeroed data
    always_comb begin
        dec_ctrl    = ALU_ADD;
        dec_a       = '0;
        dec_b       = '0;
        dec_imm     = '0;
        dec_branch  = 1'b0;
        dec_illegal = 1'b0;
        unique case (opcode)
            OPC_OP: begin
                dec_a = i_rs1_data_ID;
                dec_b = i_rs2_data_ID;
                unique case (funct3)
                    3'b000: dec_ctrl = funct7_5 ? ALU_SUB : ALU_ADD;
                    3'b001: dec_ctrl = ALU_SLL;
                    3'b010: dec_ctrl = ALU_SLT;
                    3'b011: dec_ctrl = ALU_SLTU;
                    3'b100: dec_ctrl = ALU_XOR;
                    3'b101: dec_ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110: dec_ctrl = ALU_OR;
                    default: dec_ctrl = ALU_AND;
                endcase
                // funct7[5] only distinguishes SUB and SRA
                if (funct7_5 && funct3 != 3'b000 && funct3 != 3'b101) begin
                    dec_illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                dec_a   = i_rs1_data_ID;
                dec_b   = imm_i;
                dec_imm = imm_i;
                unique case (funct3)
                    3'b000: dec_ctrl = ALU_ADD;
                    3'b001: begin
                        dec_ctrl = ALU_SLL;
                        dec_b    = shamt;
                        if (funct7_5) dec_illegal = 1'b1;
                    end
                    3'b010: dec_ctrl = ALU_SLT;
                    3'b011: dec_ctrl = ALU_SLTU;
                    3'b100: dec_ctrl = ALU_XOR;
                    3'b101: begin
                        dec_ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
                        dec_b    = shamt;
                    end
                    3'b110: dec_ctrl = ALU_OR;
                    default: dec_ctrl = ALU_AND;
                endcase
            end
            OPC_BRANCH: begin
                dec_a      = i_rs1_data_ID;
                dec_b      = i_rs2_data_ID;
                dec_imm    = imm_b;
                dec_branch = 1'b1;
                unique case (funct3)
                    3'b000: dec_ctrl = ALU_BEQ;
                    3'b001: dec_ctrl = ALU_BNE;
                    3'b100: dec_ctrl = ALU_BLT;
                    3'b101: dec_ctrl = ALU_BGE;
                    3'b110: dec_ctrl = ALU_BLTU;
                    3'b111: dec_ctrl = ALU_BGEU;
                    default: dec_illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                dec_a   = i_rs1_data_ID;
                dec_b   = imm_i;
                dec_imm = imm_i;
            end
            OPC_STORE: begin
                dec_a   = i_rs1_data_ID;
                dec_b   = imm_s;
                dec_imm = imm_s;
            end
            OPC_LUI: begin
                dec_ctrl = ALU_LUI;
                dec_b    = imm_u;
                dec_imm  = imm_u;
            end
            OPC_AUIPC: begin
                dec_a   = i_pc_ID;
                dec_b   = imm_u;
                dec_imm = imm_u;
            end
            OPC_JAL: begin
                dec_a   = i_pc_ID;
                dec_b   = four;
                dec_imm = imm_j;
            end
            OPC_JALR: begin
                dec_a   = i_pc_ID;
                dec_b   = four;
                dec_imm = imm_i;
            end
            default: dec_illegal = 1'b1;
        endcase

        // Illegal ops carry no data and are never flagged as branches
        if (dec_illegal) begin
            dec_ctrl   = ALU_ADD;
            dec_a      = '0;
            dec_b      = '0;
            dec_imm    = '0;
            dec_branch = 1'b0;
        end
    end

    // ID/EX slot registers
    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [WIDTH-1:0]  rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
    logic              branch_q, branch_d, illegal_q, illegal_d;
    logic              transfer;

    assign o_ready_ID = !valid_q || i_ready_EX;
    assign transfer   = i_valid_ID && o_ready_ID;

    // Slot next-state: flush > transfer > consume > hold
    always_comb begin
        valid_d   = valid_q;
        ctrl_d    = ctrl_q;
        rd1_d     = rd1_q;
        rd2_d     = rd2_q;
        imm_d     = imm_q;
        branch_d  = branch_q;
        illegal_d = illegal_q;
        if (i_flush_EX) begin
            valid_d   = 1'b0;
            ctrl_d    = '0;
            rd1_d     = '0;
            rd2_d     = '0;
            imm_d     = '0;
            branch_d  = 1'b0;
            illegal_d = 1'b0;
        end else if (transfer) begin
            valid_d   = 1'b1;
            ctrl_d    = dec_ctrl;
            rd1_d     = dec_a;
            rd2_d     = dec_b;
            imm_d     = dec_imm;
            branch_d  = dec_branch;
            illegal_d = dec_illegal;
        end else if (i_ready_EX) begin
            valid_d = 1'b0;
        end
    end

    // Slot state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            rd1_q     <= '0;
            rd2_q     <= '0;
            imm_q     <= '0;
            branch_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            rd1_q     <= rd1_d;
            rd2_q     <= rd2_d;
            imm_q     <= imm_d;
            branch_q  <= branch_d;
            illegal_q <= illegal_d;
        end
    end

    assign o_valid_EX    = valid_q;
    assign o_alu_ctrl_EX = ctrl_q;
    assign o_rd1_EX      = rd1_q;
    assign o_rd2_EX      = rd2_q;
    assign o_imm_EX      = imm_q;
    assign o_branch_EX   = branch_q;
    assign o_illegal_EX  = illegal_q;

endmodule

// File: tb/tb_alu_op_issue.sv
// Testbench for alu_op_issue: table of directed decode vectors applied at
// full throughput, followed by hand-written stall, flush and reset sequences.
module tb_alu_op_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_id;
    logic        ready_id;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        flush;
    logic        ready_ex;
    logic        valid_ex;
    logic [4:0]  ctrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic        branch;
    logic        illegal;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    alu_op_issue #(.WIDTH(32)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_valid_ID    (valid_id),
        .o_ready_ID    (ready_id),
        .i_instr_ID    (instr),
        .i_pc_ID       (pc),
        .i_rs1_data_ID (rs1),
        .i_rs2_data_ID (rs2),
        .i_flush_EX    (flush),
        .i_ready_EX    (ready_ex),
        .o_valid_EX    (valid_ex),
        .o_alu_ctrl_EX (ctrl),
        .o_rd1_EX      (rd1),
        .o_rd2_EX      (rd2),
        .o_imm_EX      (imm),
        .o_branch_EX   (branch),
        .o_illegal_EX  (illegal)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  ctrl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic        branch;
        logic        illegal;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs[NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic chk_slot(input string name, input logic v, input logic [4:0] c,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] im, input logic br, input logic il);
        chk({name, ".valid"},   32'(valid_ex), 32'(v));
        chk({name, ".ctrl"},    32'(ctrl),     32'(c));
        chk({name, ".rd1"},     rd1,           a);
        chk({name, ".rd2"},     rd2,           b);
        chk({name, ".imm"},     imm,           im);
        chk({name, ".branch"},  32'(branch),   32'(br));
        chk({name, ".illegal"}, 32'(illegal),  32'(il));
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin : main
        //              instr         pc          rs1           rs2          ctrl  rd1           rd2           imm          br ill
        vecs[0]  = '{32'h40B50533, 32'h100, 32'd9,        32'd4,       5'd4,  32'd9,        32'd4,        32'h0,        1'b0, 1'b0}; // sub
        vecs[1]  = '{32'h40335293, 32'h104, 32'h80000000, 32'h55,      5'd9,  32'h80000000, 32'h3,        32'h403,      1'b0, 1'b0}; // srai
        vecs[2]  = '{32'h123450B7, 32'h108, 32'hAAAA,     32'hBBBB,    5'd16, 32'h0,        32'h12345000, 32'h12345000, 1'b0, 1'b0}; // lui
        vecs[3]  = '{32'h00B56463, 32'h10C, 32'd1,        32'd2,       5'd13, 32'd1,        32'd2,        32'h8,        1'b1, 1'b0}; // bltu +8
        vecs[4]  = '{32'hFEB50EE3, 32'h110, 32'd3,        32'd3,       5'd10, 32'd3,        32'd3,        32'hFFFFFFFC, 1'b1, 1'b0}; // beq -4
        vecs[5]  = '{32'hFFF10093, 32'h114, 32'd7,        32'd8,       5'd3,  32'd7,        32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0}; // addi -1
        vecs[6]  = '{32'h00001097, 32'h118, 32'd1,        32'd2,       5'd3,  32'h118,      32'h1000,     32'h1000,     1'b0, 1'b0}; // auipc
        vecs[7]  = '{32'h008000EF, 32'h11C, 32'd1,        32'd2,       5'd3,  32'h11C,      32'd4,        32'h8,        1'b0, 1'b0}; // jal +8
        vecs[8]  = '{32'h00B52223, 32'h120, 32'h2000,     32'h77,      5'd3,  32'h2000,     32'd4,        32'h4,        1'b0, 1'b0}; // sw 4
        vecs[9]  = '{32'h00B53533, 32'h124, 32'd5,        32'd6,       5'd8,  32'd5,        32'd6,        32'h0,        1'b0, 1'b0}; // sltu
        vecs[10] = '{32'h0000007F, 32'h128, 32'd5,        32'd6,       5'd3,  32'h0,        32'h0,        32'h0,        1'b0, 1'b1}; // opcode 0x7F
        vecs[11] = '{32'h00B52063, 32'h12C, 32'd5,        32'd6,       5'd3,  32'h0,        32'h0,        32'h0,        1'b0, 1'b1}; // branch f3=010
        vecs[12] = '{32'h40131093, 32'h130, 32'd5,        32'd6,       5'd3,  32'h0,        32'h0,        32'h0,        1'b0, 1'b1}; // slli f7[5]=1
        vecs[13] = '{32'h40B55533, 32'h134, 32'hF0000000, 32'd4,       5'd9,  32'hF0000000, 32'd4,        32'h0,        1'b0, 1'b0}; // sra
        vecs[14] = '{32'h010100E7, 32'h200, 32'h1000,     32'd9,       5'd3,  32'h200,      32'd4,        32'h10,       1'b0, 1'b0}; // jalr 16
        vecs[15] = '{32'hFF812283, 32'h204, 32'h3000,     32'd9,       5'd3,  32'h3000,     32'hFFFFFFF8, 32'hFFFFFFF8, 1'b0, 1'b0}; // lw -8

        rst_n    = 1'b0;
        valid_id = 1'b0;
        instr    = 32'h0;
        pc       = 32'h0;
        rs1      = 32'h0;
        rs2      = 32'h0;
        flush    = 1'b0;
        ready_ex = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_slot("reset", 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("reset.ready_id", 32'(ready_id), 32'd1);

        // Table vectors, back-to-back with EX always ready
        @(negedge clk);
        rst_n    = 1'b1;
        ready_ex = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            valid_id = 1'b1;
            instr    = vecs[i].instr;
            pc       = vecs[i].pc;
            rs1      = vecs[i].rs1;
            rs2      = vecs[i].rs2;
            @(posedge clk);
            #1;
            chk_slot($sformatf("vec%0d", i), 1'b1, vecs[i].ctrl, vecs[i].rd1,
                     vecs[i].rd2, vecs[i].imm, vecs[i].branch, vecs[i].illegal);
            chk($sformatf("vec%0d.ready_id", i), 32'(ready_id), 32'd1);
            @(negedge clk);
        end
        valid_id = 1'b0;
        @(posedge clk);
        #1;
        chk("drain.valid", 32'(valid_ex), 32'd0);

        // Stall: op held for 3 cycles while a different op waits in ID
        @(negedge clk);
        valid_id = 1'b1;
        ready_ex = 1'b0;
        instr    = 32'h40B50533;  // sub
        pc       = 32'h300;
        rs1      = 32'd20;
        rs2      = 32'd3;
        @(posedge clk);
        #1;
        chk_slot("stall.load", 1'b1, 5'd4, 32'd20, 32'd3, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        instr = 32'h00B50533;     // add, must not be taken while stalled
        rs1   = 32'd100;
        rs2   = 32'd200;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("stall%0d.ready_id", c), 32'(ready_id), 32'd0);
            chk_slot($sformatf("stall%0d", c), 1'b1, 5'd4, 32'd20, 32'd3, 32'h0, 1'b0, 1'b0);
        end
        @(negedge clk);
        valid_id = 1'b0;
        ready_ex = 1'b1;
        #1;
        chk("consume.ready_id", 32'(ready_id), 32'd1);
        @(posedge clk);
        #1;
        chk_slot("consume", 1'b0, 5'd4, 32'd20, 32'd3, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("consume_once.valid", 32'(valid_ex), 32'd0);

        // Flush with a valid ID op on the same edge
        @(negedge clk);
        valid_id = 1'b1;
        instr    = 32'h123450B7;  // lui
        @(posedge clk);
        #1;
        chk_slot("preflush", 1'b1, 5'd16, 32'h0, 32'h12345000, 32'h12345000, 1'b0, 1'b0);
        @(negedge clk);
        flush = 1'b1;
        instr = 32'h40B50533;
        rs1   = 32'd9;
        rs2   = 32'd4;
        @(posedge clk);
        #1;
        chk_slot("flush", 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        flush    = 1'b0;
        valid_id = 1'b0;

        // Reset asserted mid-stall clears outputs without a clock edge
        @(negedge clk);
        valid_id = 1'b1;
        ready_ex = 1'b0;
        instr    = 32'h00B56463;  // bltu
        rs1      = 32'd1;
        rs2      = 32'd2;
        @(posedge clk);
        #1;
        chk_slot("prerst", 1'b1, 5'd13, 32'd1, 32'd2, 32'h8, 1'b1, 1'b0);
        @(negedge clk);
        valid_id = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk_slot("async_rst", 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        valid_id = 1'b1;
        instr    = 32'h00B53533;  // sltu
        rs1      = 32'd11;
        rs2      = 32'd12;
        @(posedge clk);
        #1;
        chk_slot("post_rst", 1'b1, 5'd8, 32'd11, 32'd12, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        valid_id = 1'b0;
        ready_ex = 1'b1;
        @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
